// File: rtl/fb_sched_pkg.sv
// Shared types and helpers for the triple-buffer frame bank scheduler.
package fb_sched_pkg;

  localparam int BANK_W = 2;

  typedef logic [BANK_W-1:0] bank_t;

  localparam bank_t WR_BANK_RESET    = 2'd0;
  localparam bank_t RD_BANK_RESET    = 2'd1;
  localparam bank_t READY_BANK_RESET = 2'd2;

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } arm_state_t;

  // The three banks are 0..2, so the one not used by a and b is 3-a-b.
  function automatic bank_t third_bank(input bank_t a, input bank_t b);
    return bank_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/vs_sync_edge.sv
// Two-flop synchronizer for a foreign VSYNC plus a registered one-cycle pulse
// on entry into the active level (POL). The pulse lands 3 clocks after the edge.
module vs_sync_edge #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic evt
);

  // sync[0], sync[1] are the synchronizer; sync[2] is the previous settled value.
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {3{~POL}};
      evt  <= 1'b0;
    end else begin
      sync <= {sync[1:0], vs};
      evt  <= (sync[1] == POL) && (sync[2] != POL);
    end
  end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: rotates writer/reader/pending banks on VSYNC
// events so the DMA never writes and reads the same frame bank.
module frame_bank_scheduler
  import fb_sched_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 22,
  parameter logic [ADDR_WIDTH-1:0] BANK_WORDS = ADDR_WIDTH'(22'h0A_0000),
  parameter logic                  WR_VS_POL  = 1'b0,
  parameter logic                  RD_VS_POL  = 1'b1,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  input  logic                  ien,
  input  logic                  iwr_vs,
  input  logic                  ird_vs,
  input  logic                  ifreeze,
  input  logic                  iclr_stats,
  output logic [1:0]            owr_bank,
  output logic [1:0]            ord_bank,
  output logic [ADDR_WIDTH-1:0] owr_base,
  output logic [ADDR_WIDTH-1:0] ord_base,
  output logic                  oready_valid,
  output logic [CNT_WIDTH-1:0]  odrop_cnt,
  output logic [CNT_WIDTH-1:0]  orepeat_cnt
);

  logic wr_evt_raw, rd_evt_raw;
  logic wr_evt, rd_evt;

  vs_sync_edge #(.POL(WR_VS_POL)) u_wr_sync (
    .clk   (iclk),
    .rst_n (irst_n),
    .vs    (iwr_vs),
    .evt   (wr_evt_raw)
  );

  vs_sync_edge #(.POL(RD_VS_POL)) u_rd_sync (
    .clk   (iclk),
    .rst_n (irst_n),
    .vs    (ird_vs),
    .evt   (rd_evt_raw)
  );

  // Synchronizers keep running while disabled so a VS already active at
  // enable time does not fake an edge.
  assign wr_evt = wr_evt_raw & ien;
  assign rd_evt = rd_evt_raw & ien;

  // Arm FSM: the first writer frame after reset/enable is partial and only arms.
  arm_state_t state, state_nx;
  logic       armed;
  logic       publish;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= ST_DISARMED;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!ien)                                state_nx = ST_DISARMED;
    else if (wr_evt && state == ST_DISARMED) state_nx = ST_ARMED;
  end

  always_comb begin
    armed   = (state == ST_ARMED);
    publish = wr_evt && armed && !ifreeze;
  end

  function automatic logic [ADDR_WIDTH-1:0] base_of(input bank_t b);
    return ADDR_WIDTH'(b) * BANK_WORDS;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_step(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic clr);
    if (clr)                    return '0;
    else if (inc && cnt != '1)  return cnt + 1'b1;
    else                        return cnt;
  endfunction

  bank_t                ready_bank;
  bank_t                wr_nx, rd_nx, ready_nx;
  logic                 valid_nx;
  logic                 drop_inc, rep_inc, clr_cnt;
  logic [CNT_WIDTH-1:0] drop_nx, rep_nx;

  // Writer update is applied first so a same-cycle reader sees the new frame.
  always_comb begin
    wr_nx    = owr_bank;
    rd_nx    = ord_bank;
    ready_nx = ready_bank;
    valid_nx = oready_valid;
    drop_inc = 1'b0;
    rep_inc  = 1'b0;
    clr_cnt  = iclr_stats;
    if (!ien) begin
      wr_nx    = WR_BANK_RESET;
      rd_nx    = RD_BANK_RESET;
      ready_nx = READY_BANK_RESET;
      valid_nx = 1'b0;
      clr_cnt  = 1'b1;
    end else begin
      if (publish) begin
        ready_nx = owr_bank;
        valid_nx = 1'b1;
        wr_nx    = third_bank(owr_bank, ord_bank);
        drop_inc = oready_valid;
      end
      if (rd_evt) begin
        if (valid_nx) begin
          rd_nx    = ready_nx;
          valid_nx = 1'b0;
        end else begin
          rep_inc = 1'b1;
        end
      end
    end
    drop_nx = sat_step(odrop_cnt, drop_inc, clr_cnt);
    rep_nx  = sat_step(orepeat_cnt, rep_inc, clr_cnt);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      owr_bank     <= WR_BANK_RESET;
      ord_bank     <= RD_BANK_RESET;
      ready_bank   <= READY_BANK_RESET;
      oready_valid <= 1'b0;
      owr_base     <= base_of(WR_BANK_RESET);
      ord_base     <= base_of(RD_BANK_RESET);
      odrop_cnt    <= '0;
      orepeat_cnt  <= '0;
    end else begin
      owr_bank     <= wr_nx;
      ord_bank     <= rd_nx;
      ready_bank   <= ready_nx;
      oready_valid <= valid_nx;
      owr_base     <= base_of(wr_nx);
      ord_base     <= base_of(rd_nx);
      odrop_cnt    <= drop_nx;
      orepeat_cnt  <= rep_nx;
    end
  end

  a_wr_ne_rd: assert property (@(posedge iclk) disable iff (!irst_n)
    owr_bank != ord_bank);
  a_wr_ne_ready: assert property (@(posedge iclk) disable iff (!irst_n)
    owr_bank != ready_bank);
  a_banks_legal: assert property (@(posedge iclk) disable iff (!irst_n)
    owr_bank != 2'd3 && ord_bank != 2'd3 && ready_bank != 2'd3);

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed plus randomized bench for frame_bank_scheduler against a
// role-based triple-buffer model.
module tb_frame_bank_scheduler;

  localparam int   AW      = 22;
  localparam int   CW      = 8;
  localparam int   BANK_SZ = 'h0A_0000;
  localparam logic WR_ACT  = 1'b0;
  localparam logic RD_ACT  = 1'b1;

  logic          iclk = 1'b0;
  logic          irst_n;
  logic          ien;
  logic          iwr_vs;
  logic          ird_vs;
  logic          ifreeze;
  logic          iclr_stats;
  logic [1:0]    owr_bank, ord_bank;
  logic [AW-1:0] owr_base, ord_base;
  logic          oready_valid;
  logic [CW-1:0] odrop_cnt, orepeat_cnt;

  frame_bank_scheduler dut (
    .iclk         (iclk),
    .irst_n       (irst_n),
    .ien          (ien),
    .iwr_vs       (iwr_vs),
    .ird_vs       (ird_vs),
    .ifreeze      (ifreeze),
    .iclr_stats   (iclr_stats),
    .owr_bank     (owr_bank),
    .ord_bank     (ord_bank),
    .owr_base     (owr_base),
    .ord_base     (ord_base),
    .oready_valid (oready_valid),
    .odrop_cnt    (odrop_cnt),
    .orepeat_cnt  (orepeat_cnt)
  );

  always #5 iclk = ~iclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total  = 0;
  int passed = 0;

  // Reference model: banks tracked by role, counters as plain integers.
  int m_wr, m_rd, m_ready, m_drop, m_rep;
  bit m_valid, m_armed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 1; m_ready = 2; m_valid = 0; m_armed = 0;
    m_drop = 0; m_rep = 0;
  endtask

  function automatic int free_bank(input int a, input int b);
    int f = -1;
    for (int k = 0; k < 3; k++) if (k != a && k != b) f = k;
    return f;
  endfunction

  task automatic model_event(input bit w, input bit r, input bit frz);
    int other;
    if (w) begin
      if (!m_armed) m_armed = 1;
      else if (!frz) begin
        other = free_bank(m_wr, m_rd);
        if (m_valid && m_drop < 255) m_drop++;
        m_ready = m_wr;
        m_valid = 1;
        m_wr    = other;
      end
    end
    if (r) begin
      if (m_valid) begin
        m_rd    = m_ready;
        m_valid = 0;
      end else if (m_rep < 255) m_rep++;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wr"},    owr_bank, m_wr);
    chk({tag, ".rd"},    ord_bank, m_rd);
    chk({tag, ".valid"}, oready_valid, m_valid);
    chk({tag, ".wbase"}, owr_base, m_wr * BANK_SZ);
    chk({tag, ".rbase"}, ord_base, m_rd * BANK_SZ);
    chk({tag, ".drop"},  odrop_cnt, m_drop);
    chk({tag, ".rep"},   orepeat_cnt, m_rep);
    chk({tag, ".inv"},   (owr_bank != ord_bank) && owr_bank < 3 && ord_bank < 3, 1);
  endtask

  // One VS pulse pair; outputs must hold for 3 edges and update on the 4th.
  task automatic fire(input bit w, input bit r, input bit full, input string tag);
    @(negedge iclk);
    if (w) iwr_vs = WR_ACT;
    if (r) ird_vs = RD_ACT;
    repeat (3) @(posedge iclk);
    #1;
    if (full) begin
      chk({tag, ".lat_wr"},    owr_bank, m_wr);
      chk({tag, ".lat_rd"},    ord_bank, m_rd);
      chk({tag, ".lat_valid"}, oready_valid, m_valid);
    end
    if (ien) model_event(w, r, ifreeze);
    if (iclr_stats || !ien) begin m_drop = 0; m_rep = 0; end
    @(posedge iclk);
    #1;
    if (full) check_outputs(tag);
    @(negedge iclk);
    iwr_vs = ~WR_ACT;
    ird_vs = ~RD_ACT;
    repeat (4) @(posedge iclk);
  endtask

  task automatic pulse_clr();
    @(negedge iclk);
    iclr_stats = 1'b1;
    @(posedge iclk);
    #1;
    m_drop = 0; m_rep = 0;
    @(negedge iclk);
    iclr_stats = 1'b0;
    chk("clr.drop", odrop_cnt, m_drop);
    chk("clr.rep",  orepeat_cnt, m_rep);
  endtask

  task automatic ien_cycle(input string tag);
    @(negedge iclk);
    ien = 1'b0;
    @(posedge iclk);
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge iclk);
    ien = 1'b1;
    repeat (2) @(posedge iclk);
  endtask

  initial begin
    irst_n = 1'b0; ien = 1'b0; iwr_vs = ~WR_ACT; ird_vs = ~RD_ACT;
    ifreeze = 1'b0; iclr_stats = 1'b0;
    model_reset();
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    irst_n = 1'b1;
    #1;
    check_outputs("reset");

    // Events while disabled must be ignored.
    fire(1, 1, 1, "disabled");
    @(negedge iclk);
    ien = 1'b1;

    // Test 1: first writer frame only arms.
    fire(1, 0, 1, "t1");
    chk("t1.wr_const", owr_bank, 0);
    chk("t1.rd_const", ord_bank, 1);

    // Test 2: publish then read.
    fire(1, 0, 1, "t2a");
    chk("t2a.wr_const", owr_bank, 2);
    fire(0, 1, 1, "t2b");
    chk("t2b.rd_const", ord_bank, 0);

    // Test 3: arm, then three frames with no reader -> two drops.
    ien_cycle("t3_rst");
    fire(1, 0, 1, "t3_arm");
    for (int i = 0; i < 3; i++) fire(1, 0, 1, "t3");
    chk("t3.drop_const", odrop_cnt, 2);
    chk("t3.rd_const",   ord_bank, 1);

    // Test 4: simultaneous events from wr=0, rd=1, nothing pending.
    ien_cycle("t4_rst");
    fire(1, 0, 1, "t4_arm");
    fire(1, 1, 1, "t4");
    chk("t4.rd_const", ord_bank, 0);
    chk("t4.wr_const", owr_bank, 2);

    // Test 5: freeze keeps banks, reader repeats.
    ifreeze = 1'b1;
    for (int i = 0; i < 4; i++) fire(1, 0, 1, "t5w");
    for (int i = 0; i < 2; i++) fire(0, 1, 1, "t5r");
    chk("t5.rep_const",  orepeat_cnt, 2);
    chk("t5.base_const", owr_base, 22'h14_0000);
    ifreeze = 1'b0;

    // Test 6: repeat counter saturation, clear, clear-beats-increment.
    for (int i = 0; i < 300; i++) fire(0, 1, 0, "t6");
    check_outputs("t6_sat");
    chk("t6.sat_const", orepeat_cnt, 255);
    pulse_clr();
    iclr_stats = 1'b1;
    fire(0, 1, 1, "t6_clr_prio");
    iclr_stats = 1'b0;

    // Disable mid-frame with the camera VS active.
    fire(1, 0, 1, "t6_pub");
    @(negedge iclk);
    iwr_vs = WR_ACT;
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    ien = 1'b0;
    @(posedge iclk);
    #1;
    model_reset();
    check_outputs("ien_drop");
    @(negedge iclk);
    iwr_vs = ~WR_ACT;
    repeat (5) @(posedge iclk);
    ien = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int sel;
      ifreeze = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(1, 3);
      fire(sel[0], sel[1], 1, "rand");
      if ($urandom_range(0, 19) == 0) pulse_clr();
      if ($urandom_range(0, 39) == 0) ien_cycle("rand_ien");
    end
    ifreeze = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
